// File: rtl/burst_envelope_gen_pkg.sv
// Shared definitions for the burst envelope generator.
// Holds the envelope FSM state encoding (IDLE=0, ATTACK=1, SUSTAIN=2, RELEASE=3).
package burst_envelope_gen_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ATTACK  = 2'd1,
    SUSTAIN = 2'd2,
    RELEASE = 2'd3
  } env_state_e;

endpackage

// File: rtl/square_carrier.sv
// Square-wave carrier: half-period counter plus phase flip-flop.
// Ports:
//   clk      sample clock
//   rst      synchronous active-high reset
//   advance  count one enabled sample
//   restart  treat this sample as counter 0, phase 0 (start of a fresh burst)
//   phase    registered carrier phase (0 = positive half, 1 = negative half)
module square_carrier #(
  parameter int unsigned HALF_PERIOD = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic advance,
  input  logic restart,
  output logic phase
);

  localparam int unsigned CW = (HALF_PERIOD > 1) ? $clog2(HALF_PERIOD) : 1;
  localparam logic [CW-1:0] LAST = CW'(HALF_PERIOD - 1);

  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_base_c;
  logic          phase_base_c;

  // A restart sample counts as position 0 of phase 0 before advancing.
  assign cnt_base_c   = restart ? '0 : cnt;
  assign phase_base_c = restart ? 1'b0 : phase;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt   <= '0;
      phase <= 1'b0;
    end else if (advance) begin
      if (cnt_base_c == LAST) begin
        cnt   <= '0;
        phase <= ~phase_base_c;
      end else begin
        cnt   <= cnt_base_c + CW'(1);
        phase <= phase_base_c;
      end
    end else if (restart) begin
      cnt   <= '0;
      phase <= 1'b0;
    end
  end

endmodule

// File: rtl/burst_envelope_gen.sv
// Gated burst generator: signed square-wave carrier under an
// attack/sustain/release envelope.
// Ports:
//   clk        sample clock
//   rst        synchronous active-high reset
//   sampleEn   sample strobe; everything advances only on strobe cycles
//   gate       burst request, sampled on strobe cycles
//   ampTarget  unsigned sustain magnitude, latched at burst start / retrigger
//   outData    registered signed output sample
//   outValid   registered copy of sampleEn
//   busy       registered, high while the FSM is not IDLE
module burst_envelope_gen
  import burst_envelope_gen_pkg::*;
#(
  parameter int unsigned OUT_WIDTH   = 16,
  parameter int unsigned HALF_PERIOD = 8,
  parameter int unsigned STEP        = 1024
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        sampleEn,
  input  logic                        gate,
  input  logic        [OUT_WIDTH-2:0] ampTarget,
  output logic signed [OUT_WIDTH-1:0] outData,
  output logic                        outValid,
  output logic                        busy
);

  localparam int unsigned EW = OUT_WIDTH - 1;
  localparam logic [EW-1:0] STEP_E = EW'(STEP);

  env_state_e           state, state_nxt;
  logic [EW-1:0]        env, env_nxt;
  logic [EW-1:0]        tgt, tgt_nxt;
  logic [OUT_WIDTH-1:0] sum_c;
  logic [EW-1:0]        inc_c, dec_c;
  logic                 restart_c, advance_c;
  logic                 phase, phase_eff_c;
  logic [OUT_WIDTH-1:0] mag_c, neg_c;

  // Target re-latches on burst start and on retrigger out of RELEASE.
  assign tgt_nxt = (sampleEn && gate && (state == IDLE || state == RELEASE)) ? ampTarget : tgt;

  // Saturating ramp; the sum carries one extra bit so it cannot wrap.
  assign sum_c = {1'b0, env} + OUT_WIDTH'(STEP);
  assign inc_c = (sum_c >= {1'b0, tgt_nxt}) ? tgt_nxt : sum_c[EW-1:0];
  assign dec_c = (env > STEP_E) ? (env - STEP_E) : '0;

  // Envelope FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      env   <= '0;
      tgt   <= '0;
    end else begin
      state <= state_nxt;
      env   <= env_nxt;
      tgt   <= tgt_nxt;
    end
  end

  // Envelope FSM next state; a decrement that lands on 0 ends the burst.
  always_comb begin
    state_nxt = state;
    env_nxt   = env;
    restart_c = 1'b0;
    if (sampleEn) begin
      case (state)
        IDLE: begin
          env_nxt = '0;
          if (gate) begin
            restart_c = 1'b1;
            env_nxt   = inc_c;
            state_nxt = (inc_c == tgt_nxt) ? SUSTAIN : ATTACK;
          end
        end
        ATTACK: begin
          if (!gate) begin
            env_nxt   = dec_c;
            state_nxt = (dec_c == '0) ? IDLE : RELEASE;
          end else begin
            env_nxt   = inc_c;
            state_nxt = (inc_c == tgt_nxt) ? SUSTAIN : ATTACK;
          end
        end
        SUSTAIN: begin
          if (!gate) begin
            env_nxt   = dec_c;
            state_nxt = (dec_c == '0) ? IDLE : RELEASE;
          end else begin
            env_nxt = tgt;
          end
        end
        RELEASE: begin
          if (gate) begin
            env_nxt   = inc_c;
            state_nxt = (inc_c == tgt_nxt) ? SUSTAIN : ATTACK;
          end else begin
            env_nxt   = dec_c;
            state_nxt = (dec_c == '0) ? IDLE : RELEASE;
          end
        end
      endcase
    end
  end

  // Carrier runs on every strobe of a burst, including its first sample.
  assign advance_c   = sampleEn && ((state != IDLE) || gate);
  assign phase_eff_c = restart_c ? 1'b0 : phase;

  square_carrier #(
    .HALF_PERIOD(HALF_PERIOD)
  ) u_carrier (
    .clk    (clk),
    .rst    (rst),
    .advance(advance_c),
    .restart(restart_c),
    .phase  (phase)
  );

  // Registered sign mux; magnitude fits in EW bits so the most negative code never appears.
  assign mag_c = {1'b0, env_nxt};
  assign neg_c = ~mag_c + OUT_WIDTH'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      outData  <= '0;
      outValid <= 1'b0;
      busy     <= 1'b0;
    end else begin
      outValid <= sampleEn;
      if (sampleEn) begin
        outData <= phase_eff_c ? $signed(neg_c) : $signed(mag_c);
        busy    <= (state_nxt != IDLE);
      end
    end
  end

endmodule
